// File: rtl/wb_byte_master_if.sv
// Byte-stream and Wishbone signal bundle for wb_byte_master.
// master = initiator view, slave = stream source / responder view.
interface wb_byte_master_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  wb_addr;
    logic [31:0] wb_rdata;
    logic [31:0] wb_wdata;
    logic        wb_we;
    logic        wb_cyc;
    logic        wb_ack;

    modport master (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready,
        output wb_addr,
        input  wb_rdata,
        output wb_wdata,
        output wb_we,
        output wb_cyc,
        input  wb_ack
    );

    modport slave (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  wb_addr,
        output wb_rdata,
        input  wb_wdata,
        input  wb_we,
        input  wb_cyc,
        output wb_ack
    );
endinterface

// File: rtl/wb_byte_master.sv
// Byte-serial command stream to single 32-bit Wishbone transfers,
// with a byte-serial status/read-data response stream.
module wb_byte_master #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TW      = 16
) (
    input  logic                clk,
    input  logic                rst,
    wb_byte_master_if.master    bus,
    output logic                busy
);

    typedef enum logic [2:0] {
        S_CMD,
        S_ADDR,
        S_WDATA,
        S_BUS,
        S_RSP
    } state_t;

    localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic          we_q, we_d;
    logic [7:0]    addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          tout_q, tout_d;
    logic          sts_pend_q, sts_pend_d;
    logic [1:0]    idx_q, idx_d;
    logic [TW-1:0] cnt_q, cnt_d;

    logic          in_rdy;
    logic          in_fire;
    logic          out_fire;
    logic [7:0]    rsp_byte;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_CMD;
            we_q       <= 1'b0;
            addr_q     <= 8'h00;
            wdata_q    <= 32'h0;
            rdata_q    <= 32'h0;
            tout_q     <= 1'b0;
            sts_pend_q <= 1'b0;
            idx_q      <= 2'd0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            tout_q     <= tout_d;
            sts_pend_q <= sts_pend_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        in_rdy   = (state_q == S_CMD) ||
                   (state_q == S_ADDR) ||
                   (state_q == S_WDATA);
        in_fire  = bus.in_valid & in_rdy;
        out_fire = (state_q == S_RSP) & bus.out_ready;
    end

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        tout_d     = tout_q;
        sts_pend_d = sts_pend_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;

        unique case (state_q)
            S_CMD: begin
                if (in_fire) begin
                    we_d    = bus.in_data[7];
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (in_fire) begin
                    addr_d  = bus.in_data;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                    state_d = we_q ? S_WDATA : S_BUS;
                end
            end
            S_WDATA: begin
                if (in_fire) begin
                    unique case (idx_q)
                        2'd0: wdata_d[7:0]   = bus.in_data;
                        2'd1: wdata_d[15:8]  = bus.in_data;
                        2'd2: wdata_d[23:16] = bus.in_data;
                        2'd3: wdata_d[31:24] = bus.in_data;
                        default: ;
                    endcase
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        cnt_d   = '0;
                        state_d = S_BUS;
                    end
                end
            end
            S_BUS: begin
                // ack takes priority over a coincident terminal count
                if (bus.wb_ack) begin
                    rdata_d    = bus.wb_rdata;
                    tout_d     = 1'b0;
                    sts_pend_d = 1'b1;
                    idx_d      = 2'd0;
                    state_d    = S_RSP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d    = 32'h0;
                    tout_d     = 1'b1;
                    sts_pend_d = 1'b1;
                    idx_d      = 2'd0;
                    state_d    = S_RSP;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            S_RSP: begin
                if (out_fire) begin
                    if (sts_pend_q) begin
                        sts_pend_d = 1'b0;
                        if (we_q) begin
                            state_d = S_CMD;
                        end
                    end else begin
                        idx_d = idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            state_d = S_CMD;
                        end
                    end
                end
            end
            default: begin
                state_d = S_CMD;
            end
        endcase
    end

    always_comb begin
        rsp_byte = 8'h00;
        if (sts_pend_q) begin
            rsp_byte = {7'd0, tout_q};
        end else begin
            unique case (idx_q)
                2'd0: rsp_byte = rdata_q[7:0];
                2'd1: rsp_byte = rdata_q[15:8];
                2'd2: rsp_byte = rdata_q[23:16];
                2'd3: rsp_byte = rdata_q[31:24];
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.in_ready  = in_rdy;
        bus.out_valid = (state_q == S_RSP);
        bus.out_data  = (state_q == S_RSP) ? rsp_byte : 8'h00;
        bus.wb_cyc    = (state_q == S_BUS);
        bus.wb_we     = we_q;
        bus.wb_addr   = addr_q;
        bus.wb_wdata  = wdata_q;
        busy          = (state_q != S_CMD);
    end

endmodule

// File: tb/tb_wb_byte_master.sv
// Directed bench for wb_byte_master with a frame-level reference model
// checked every cycle, plus literal expectations per scenario.
module tb_wb_byte_master;

    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;

    wb_byte_master_if bif();

    wb_byte_master #(.TIMEOUT(TO), .TW(16)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bif),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  fr[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  log_q[$];
    bit          in_bus = 0;
    bit          bus_on = 0;
    int          bus_k = 0;
    int          cyc_len = 0;
    int          last_len = 0;
    int          exp_len = 0;
    logic [7:0]  exp_addr = 0;
    bit          exp_we = 0;
    logic [31:0] exp_wdata = 0;
    logic [31:0] rd_val = 0;
    int          ack_at = 0;
    bit          stray = 0;
    bit          rdy_toggle = 0;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    task automatic chk_log(input string name, input logic [7:0] e[$]);
        chk({name, "_len"}, log_q.size(), e.size());
        for (int i = 0; i < e.size() && i < log_q.size(); i++)
            chk(name, log_q[i], e[i]);
    endtask

    // Reference model: frames in, expected bus cycle and response bytes out
    always @(negedge clk) begin
        if (rst) begin
            fr.delete();
            exp_q.delete();
            in_bus = 0;
            bus_on = 0;
            bif.wb_ack = 1'b0;
        end else begin
            chk("in_ready", bif.in_ready, !(in_bus || exp_q.size() != 0));
            chk("busy", busy,
                in_bus || exp_q.size() != 0 || fr.size() != 0);
            if (bus_on) begin
                bus_k++;
                if (bif.wb_cyc) begin
                    cyc_len++;
                    chk("wb_addr", bif.wb_addr, exp_addr);
                    chk("wb_we", bif.wb_we, exp_we);
                    if (exp_we) chk("wb_wdata", bif.wb_wdata, exp_wdata);
                end else if (in_bus) begin
                    in_bus = 0;
                    last_len = cyc_len;
                    chk("cyc_len", cyc_len, exp_len);
                end
                if (bus_k > 64) bus_on = 0;
            end
            bif.wb_ack = (bus_on && bus_k == ack_at) || stray;
            chk("wb_cyc", bif.wb_cyc, in_bus);
            chk("out_valid", bif.out_valid, !in_bus && exp_q.size() != 0);
            if (bif.out_valid && exp_q.size() != 0) begin
                chk("out_data", bif.out_data, exp_q[0]);
                if (bif.out_ready) begin
                    log_q.push_back(bif.out_data);
                    void'(exp_q.pop_front());
                end
            end
            if (bif.in_valid && bif.in_ready) begin
                fr.push_back(bif.in_data);
                if ((fr.size() == 2 && !fr[0][7]) || fr.size() == 6) begin
                    bit ok;
                    exp_we = fr[0][7];
                    exp_addr = fr[1];
                    if (exp_we) exp_wdata = {fr[5], fr[4], fr[3], fr[2]};
                    ok = (ack_at >= 1) && (ack_at <= TO);
                    exp_len = ok ? ack_at : TO;
                    exp_q.push_back(ok ? 8'h00 : 8'h01);
                    if (!exp_we)
                        for (int i = 0; i < 4; i++)
                            exp_q.push_back(ok ? rd_val[8*i +: 8] : 8'h00);
                    fr.delete();
                    in_bus = 1;
                    bus_on = 1;
                    bus_k = 0;
                    cyc_len = 0;
                end
            end
        end
    end

    initial begin
        bif.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_toggle) bif.out_ready = ~bif.out_ready;
            else bif.out_ready = 1'b1;
        end
    end

    assign bif.wb_rdata = rd_val;

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        int t = 0;
        bif.in_data = b;
        bif.in_valid = 1'b1;
        @(negedge clk);
        while (!bif.in_ready && t < 300) begin
            t++;
            @(negedge clk);
        end
        chk("send_wait", bif.in_ready, 1);
        @(posedge clk);
        #1;
        bif.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((busy || exp_q.size() != 0) && t < 400);
        repeat (2) @(negedge clk);
        chk("idle_wait", busy, 0);
    endtask

    task automatic pulse_rst();
        sync();
        rst = 1'b1;
        sync();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_cyc", bif.wb_cyc, 0);
        chk("rst_ov", bif.out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_inrdy", bif.in_ready, 1);
    endtask

    initial begin
        logic [7:0] e[$];
        bif.in_data = 8'h00;
        bif.in_valid = 1'b0;
        bif.wb_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("r_cyc", bif.wb_cyc, 0);
        chk("r_we", bif.wb_we, 0);
        chk("r_addr", bif.wb_addr, 0);
        chk("r_wdata", bif.wb_wdata, 0);
        chk("r_ov", bif.out_valid, 0);
        chk("r_od", bif.out_data, 0);
        chk("r_inrdy", bif.in_ready, 1);
        chk("r_busy", busy, 0);

        sync();
        log_q.delete();
        ack_at = 2;
        send(8'h80); send(8'h00);
        send(8'h04); send(8'h00); send(8'h00); send(8'h00);
        wait_idle();
        e = '{8'h00};
        chk_log("wr", e);
        chk("wr_len", last_len, 2);
        chk("wr_wdata", bif.wb_wdata, 32'h0000_0004);
        chk("wr_we", bif.wb_we, 1);
        chk("wr_addr", bif.wb_addr, 8'h00);

        sync();
        log_q.delete();
        ack_at = 2;
        rd_val = 32'h1234_5678;
        send(8'h00); send(8'h07);
        wait_idle();
        e = '{8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        chk_log("rd", e);
        chk("rd_we", bif.wb_we, 0);
        chk("rd_addr", bif.wb_addr, 8'h07);

        sync();
        log_q.delete();
        ack_at = 10;
        rd_val = 32'hDEAD_BEEF;
        send(8'h00); send(8'h03);
        wait_idle();
        e = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        chk_log("to", e);
        chk("to_len", last_len, 8);

        sync();
        log_q.delete();
        ack_at = 8;
        rd_val = 32'hA5C3_0F96;
        send(8'h00); send(8'h05);
        wait_idle();
        e = '{8'h00, 8'h96, 8'h0F, 8'hC3, 8'hA5};
        chk_log("tie", e);
        chk("tie_len", last_len, 8);

        sync();
        log_q.delete();
        rdy_toggle = 1;
        ack_at = 3;
        rd_val = 32'hCAFE_F00D;
        send(8'h00); send(8'h11);
        send(8'h80); send(8'h22);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        wait_idle();
        rdy_toggle = 0;
        e = '{8'h00, 8'h0D, 8'hF0, 8'hFE, 8'hCA, 8'h00};
        chk_log("bp", e);
        chk("bp_wdata", bif.wb_wdata, 32'h4433_2211);
        chk("bp_addr", bif.wb_addr, 8'h22);

        sync();
        stray = 1;
        repeat (3) sync();
        stray = 0;
        @(negedge clk);
        chk("stray_busy", busy, 0);

        sync();
        ack_at = 0;
        send(8'h00); send(8'h09);
        repeat (3) @(negedge clk);
        chk("bus_before_rst", bif.wb_cyc, 1);
        pulse_rst();

        sync();
        send(8'h80); send(8'h30); send(8'hAA); send(8'hBB);
        pulse_rst();

        sync();
        log_q.delete();
        ack_at = 2;
        rd_val = 32'h0BAD_F00D;
        send(8'h00); send(8'h04);
        wait_idle();
        e = '{8'h00, 8'h0D, 8'hF0, 8'hAD, 8'h0B};
        chk_log("post", e);
        chk("post_addr", bif.wb_addr, 8'h04);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

    initial begin
        #300000;
        n_err++;
        $display("FAIL watchdog: run did not complete");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wb_byte_master.md
Name: wb_byte_master

Overview:
- Wishbone initiator that converts a byte-serial command stream (from the USB/UART control path) into single 32-bit Wishbone reads and writes.
- Returns a byte-serial response stream.
- Drives the 8-bit-address peripheral bus that the misc, E1 and other responder blocks sit on. Exactly one transaction is in flight at a time.

Parameters:
- TIMEOUT, 255: cycles wb_cyc may stay high without wb_ack before the transaction is aborted. Legal range 1..65535.
- TW, 16: width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- in_data  in  8  command byte
- in_valid  in  1  command byte present
- in_ready  out  1  command byte accepted when in_valid & in_ready
- out_data  out  8  response byte
- out_valid  out  1  response byte present
- out_ready  in  1  response byte consumed when out_valid & out_ready
- wb_addr  out  8  bus address
- wb_rdata  in  32  bus read data, valid with wb_ack
- wb_wdata  out  32  bus write data
- wb_we  out  1  write strobe qualifier
- wb_cyc  out  1  cycle/strobe
- wb_ack  in  1  responder acknowledge
- busy  out  1  high in any state other than CMD

Behaviour:
- One clock, synchronous active-high reset.
- Outputs after reset:
  - wb_cyc=0, wb_we=0, wb_addr=0, wb_wdata=0
  - out_valid=0, out_data=0
  - in_ready=1, busy=0
  - state=CMD
- Command frame:
  - Header byte: bit7 is the write flag; bits 6:0 are ignored.
  - Then the address byte.
  - For writes only, 4 data bytes follow, LSB first.
- Response frame:
  - Status byte: 0x00 = ack received, 0x01 = timeout.
  - For reads only, 4 rdata bytes follow, LSB first.
  - On a read timeout the data bytes are 0x00.
- States and transitions:
  - CMD: latch the header's write flag into wb_we. Go to ADDR.
  - ADDR: latch wb_addr. Go to WDATA if write, else BUS.
  - WDATA: shift the 4 bytes into wb_wdata[7:0], [15:8], [23:16], [31:24] using a 2-bit byte index. After the 4th byte, go to BUS.
  - BUS: wb_cyc=1. On wb_ack: capture wb_rdata, set status=0x00, drop wb_cyc, go to RSP. Otherwise, when the timeout counter reaches TIMEOUT-1: drop wb_cyc, set status=0x01, clear the read-data register, go to RSP.
  - RSP: present the status byte, then (reads only) the 4 data bytes with a 2-bit index. After the last byte is consumed, go to CMD.
- in_ready=1 only in CMD, ADDR and WDATA. Input bytes arriving in BUS or RSP are back-pressured, never dropped.
- Latency:
  - wb_cyc rises on the clock edge that accepts the last command byte.
  - wb_cyc falls on the edge where wb_ack=1 is sampled, so a responder that acks one cycle after cyc sees exactly 2 cycles of cyc.
  - out_valid rises on that same edge.
- Bus stability: wb_addr, wb_we and wb_wdata are stable for the whole time wb_cyc=1. They hold their last values after the cycle ends.
- wb_ack is ignored while wb_cyc=0. A stray ack has no effect in any state.
- Timeout counter:
  - Cleared on BUS entry; increments each BUS cycle without ack.
  - If ack and the terminal count occur in the same cycle, ack wins: status 0x00, data captured.
  - TIMEOUT=1 means exactly 1 cycle of wb_cyc before abort.
- out_valid is held with stable out_data until out_ready. Back-to-back consumption (out_ready held high) yields one byte per cycle.
- Reset mid-operation: partial command discarded, wb_cyc drops on the reset edge, any pending response is discarded, state=CMD.
- The next command may be presented while the last response byte is being accepted. It is taken on the cycle after the return to CMD.

Test Plan:
- Write: header 0x80, addr 0x00, data 04 00 00 00, responder acking 1 cycle after cyc → wb_cyc high 2 cycles with wb_we=1, wb_addr=0x00, wb_wdata=0x00000004; response is the single byte 0x00.
- Read: header 0x00, addr 0x07, responder returns 0x12345678 → wb_we=0; response 00 78 56 34 12, one byte per cycle with out_ready=1.
- Timeout with TIMEOUT=8 and no ack on a read → wb_cyc high exactly 8 cycles, then response 01 00 00 00 00. A late wb_ack on cycle 10 is ignored.
- Ack coincides with the terminal count (ack on the 8th cycle, TIMEOUT=8) → status 0x00 and rdata returned.
- Back-pressure: in_valid held during BUS/RSP → in_ready=0 and no byte lost. out_ready toggled 1/0 → each response byte emitted once, in order, stable while stalled.
- Reset asserted in BUS and in mid-WDATA → wb_cyc=0 next edge, out_valid=0, busy=0; a following read of 0x04 completes normally.
